skullfet_char_harness: RTL

//  Stimulus/response harness around the skullfet_inverter.
//  - Upstream: drives the inverter input A with a programmable square wave.
//  - Downstream: samples Y through a synchroniser and checks Y == ~A.
//  - Measures A-to-Y latency in clocks, counts missed responses.
//  - Control and results are exchanged with the PicoRV32 over LA bits inside
//    the Caravel wrapper, so silicon inverters can be characterised without

---
 rtl/skullfet_char_pkg.sv | 17 +
 rtl/skullfet_sync.sv | 23 ++
 rtl/skullfet_char_harness.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/skullfet_char_pkg.sv
// Shared types and default sizes for the skullfet inverter characterisation harness.
package skullfet_char_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned LAT_W_DEF       = 4;
  localparam int unsigned ERR_W_DEF       = 8;

  typedef enum logic [2:0] {
    IDLE,
    TOGGLE,
    WAIT,
    HOLD,
    DONE
  } state_e;

endpackage

// File: rtl/skullfet_sync.sv
// Multi-flop synchroniser for the asynchronous inverter output.
module skullfet_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/skullfet_char_harness.sv
// Drives inverter input A with a square wave, checks the synchronised Y == ~A,
// and records worst-case toggle-to-match latency and timed-out edges.
module skullfet_char_harness
  import skullfet_char_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned LAT_W       = LAT_W_DEF,
  parameter int unsigned ERR_W       = ERR_W_DEF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] half_period,
  input  logic [CNT_W-1:0] num_edges,
  input  logic             dut_y_i,
  output logic             dut_a_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [LAT_W-1:0] max_latency
);

  state_e           state_q, state_d;
  logic             a_q, a_d;
  logic [CNT_W-1:0] hp_q, hp_d;
  logic [CNT_W-1:0] ne_q, ne_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [LAT_W-1:0] maxlat_q, maxlat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             y_sync;
  logic             y_match;
  logic [LAT_W-1:0] lat_inc;
  logic [CNT_W-1:0] per_inc;

  skullfet_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_n),
    .d_i    (dut_y_i),
    .q_o    (y_sync)
  );

  // Latency is counted including the current WAIT cycle, so it is measured
  // from the TOGGLE edge; it saturates at all-ones, which is also the timeout.
  assign lat_inc = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);
  assign per_inc = per_q + CNT_W'(1);
  assign y_match = (y_sync == ~a_q);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= IDLE;
      a_q      <= 1'b0;
      hp_q     <= '0;
      ne_q     <= '0;
      edge_q   <= '0;
      per_q    <= '0;
      lat_q    <= '0;
      err_q    <= '0;
      maxlat_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      hp_q     <= hp_d;
      ne_q     <= ne_d;
      edge_q   <= edge_d;
      per_q    <= per_d;
      lat_q    <= lat_d;
      err_q    <= err_d;
      maxlat_q <= maxlat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    hp_d     = hp_q;
    ne_d     = ne_q;
    edge_d   = edge_q;
    per_d    = per_q;
    lat_d    = lat_q;
    err_d    = err_q;
    maxlat_d = maxlat_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;

    unique case (state_q)
      TOGGLE: begin
        a_d     = ~a_q;
        lat_d   = '0;
        per_d   = '0;
        edge_d  = edge_q + CNT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_inc;
        per_d = per_inc;
        if (y_match) begin
          if (lat_inc > maxlat_q) maxlat_d = lat_inc;
          state_d = HOLD;
        end else if (lat_inc == '1) begin
          if (err_q != '1) err_d = err_q + ERR_W'(1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        per_d = per_inc;
        if (per_q >= hp_q - CNT_W'(1)) begin
          state_d = (edge_q == ne_q) ? DONE : TOGGLE;
        end
      end
      DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        pass_d = (err_q == '0);
      end
      default: ;
    endcase

    // A new run may start from IDLE or DONE; it overrides the DONE hold values.
    if ((state_q == IDLE || state_q == DONE) && start) begin
      hp_d     = (half_period == '0) ? CNT_W'(1) : half_period;
      ne_d     = num_edges;
      err_d    = '0;
      maxlat_d = '0;
      edge_d   = '0;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      pass_d   = 1'b0;
      state_d  = (num_edges == '0) ? DONE : TOGGLE;
    end
  end

  assign dut_a_o     = a_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign max_latency = maxlat_q;

endmodule
